// File: rtl/rv32_isa.sv
// RV32 base opcode constants and per-opcode operand-usage decode used by the issue scoreboard.
package rv32_isa;

    localparam int unsigned RegAddrWidth = 5;
    localparam int unsigned OpcodeWidth  = 7;

    typedef logic [OpcodeWidth-1:0] opcode_t;

    localparam opcode_t OpLui    = 7'b0110111;
    localparam opcode_t OpAuipc  = 7'b0010111;
    localparam opcode_t OpJal    = 7'b1101111;
    localparam opcode_t OpJalr   = 7'b1100111;
    localparam opcode_t OpBranch = 7'b1100011;
    localparam opcode_t OpLoad   = 7'b0000011;
    localparam opcode_t OpStore  = 7'b0100011;
    localparam opcode_t OpImm    = 7'b0010011;
    localparam opcode_t OpReg    = 7'b0110011;
    localparam opcode_t OpFence  = 7'b0001111;
    localparam opcode_t OpSystem = 7'b1110011;

    function automatic logic uses_rs1(input opcode_t op);
        case (op)
            OpJalr, OpLoad, OpImm, OpReg, OpBranch, OpStore: uses_rs1 = 1'b1;
            default:                                         uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input opcode_t op);
        case (op)
            OpReg, OpBranch, OpStore: uses_rs2 = 1'b1;
            default:                  uses_rs2 = 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input opcode_t op);
        case (op)
            OpLui, OpAuipc, OpJal, OpJalr, OpLoad, OpImm, OpReg: writes_rd = 1'b1;
            default:                                            writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic is_drain(input opcode_t op);
        case (op)
            OpFence, OpSystem: is_drain = 1'b1;
            default:           is_drain = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/reg_pending_ctr.sv
// Per-register in-flight write counter; saturating up on issue, down on writeback.
module reg_pending_ctr #(
    parameter int unsigned CntWidth = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic wb,
    output logic nonzero,
    output logic pending,
    output logic sat,
    output logic err
);

    localparam logic [CntWidth-1:0] CntMax = '1;

    logic [CntWidth-1:0] count;
    logic                dec;

    assign nonzero = (count != '0);
    assign sat     = (count == CntMax);
    assign dec     = wb & nonzero;
    assign err     = wb & ~nonzero;
    // Write-first regfile: the last pending write retiring this cycle clears the hazard.
    assign pending = nonzero & ~(dec & (count == CntWidth'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc & ~dec & ~sat) begin
            count <= count + CntWidth'(1);
        end else if (dec & ~inc) begin
            count <= count - CntWidth'(1);
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard: holds decode->issue handshake while operands have pending writes.
module issue_scoreboard
    import rv32_isa::*;
#(
    parameter int unsigned CntWidth   = 2,
    parameter int unsigned StallWidth = 32
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iValid,
    output logic                    oReady,
    input  logic [OpcodeWidth-1:0]  iOpCode,
    input  logic [RegAddrWidth-1:0] iRS1,
    input  logic [RegAddrWidth-1:0] iRS2,
    input  logic [RegAddrWidth-1:0] iRD,
    input  logic                    iFlush,
    output logic                    oIssue,
    input  logic                    iWbValid,
    input  logic [RegAddrWidth-1:0] iWbRD,
    output logic                    oBusy,
    output logic                    oErr,
    output logic [StallWidth-1:0]   oStallCnt
);

    localparam int unsigned NumRegs = 32;
    localparam logic [StallWidth-1:0] StallMax = '1;

    logic [NumRegs-1:0] nonzero;
    logic [NumRegs-1:0] pending;
    logic [NumRegs-1:0] sat;
    logic [NumRegs-1:0] ctr_err;
    logic               issue_wr;
    logic               rs1_haz;
    logic               rs2_haz;
    logic               rd_full;
    logic               drain_haz;
    logic               wb_err;

    // x0 is hardwired zero and never tracked.
    assign nonzero[0] = 1'b0;
    assign pending[0] = 1'b0;
    assign sat[0]     = 1'b0;
    assign ctr_err[0] = 1'b0;

    assign issue_wr = oIssue & writes_rd(iOpCode);

    for (genvar r = 1; r < NumRegs; r++) begin : g_ctr
        reg_pending_ctr #(.CntWidth(CntWidth)) u_ctr (
            .clk     (iClk),
            .rst     (iRst),
            .inc     (issue_wr & (iRD == RegAddrWidth'(r))),
            .wb      (iWbValid & (iWbRD == RegAddrWidth'(r))),
            .nonzero (nonzero[r]),
            .pending (pending[r]),
            .sat     (sat[r]),
            .err     (ctr_err[r])
        );
    end

    // WAW is allowed; only a saturated rd counter (before same-cycle writeback) blocks.
    assign rs1_haz   = uses_rs1(iOpCode) & pending[iRS1];
    assign rs2_haz   = uses_rs2(iOpCode) & pending[iRS2];
    assign rd_full   = writes_rd(iOpCode) & sat[iRD];
    assign drain_haz = is_drain(iOpCode) & (|pending);

    assign oReady = ~iFlush & ~rs1_haz & ~rs2_haz & ~rd_full & ~drain_haz;
    assign oIssue = iValid & oReady;
    assign oBusy  = |nonzero;
    assign wb_err = iWbValid & ((iWbRD == '0) | ctr_err[iWbRD]);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oErr      <= 1'b0;
            oStallCnt <= '0;
        end else begin
            if (wb_err) begin
                oErr <= 1'b1;
            end
            if (iValid & ~iFlush & ~oReady & (oStallCnt != StallMax)) begin
                oStallCnt <= oStallCnt + StallWidth'(1);
            end
        end
    end

endmodule
